// File: rtl/polar_pkg.sv
// Shared polar-code constants and helpers (code size defaults, FSM state codes,
// clog2 and bit-reversal) used by the encoder, decoder and frame assembler.
package polar_pkg;

    localparam int unsigned PolarN          = 16;
    localparam int unsigned PolarK          = 8;
    localparam logic [15:0] PolarFrozenMask = 16'h033F;

    typedef logic [1:0] state_t;
    localparam state_t StCollect = 2'd0;
    localparam state_t StScatter = 2'd1;
    localparam state_t StHold    = 2'd2;

    // Ceiling log2; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (v > (32'd1 << i)) r = i + 1;
        end
        return r;
    endfunction

    // Reverse the low nbits of v.
    function automatic int unsigned bitrev(input int unsigned v, input int unsigned nbits);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((i < nbits) && (((v >> i) & 32'd1) != 0)) r = r | (32'd1 << (nbits - 1 - i));
        end
        return r;
    endfunction

endpackage

// File: rtl/polar_frame_assembler.sv
// Collects K/8 info bytes, scatters them into the non-frozen positions of the polar
// u vector one position per cycle, then holds u for the encoder. POLAR_ASM_BITREV_EN
// selects bit-reversed write addresses for the scatter.
module polar_frame_assembler
    import polar_pkg::*;
#(
    parameter int unsigned  N           = PolarN,
    parameter int unsigned  K           = PolarK,
    parameter logic [N-1:0] FROZEN_MASK = N'(PolarFrozenMask)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] u_out,
    output logic         u_valid,
    input  logic         u_ready,
    output logic         busy
);

    localparam int unsigned NBytes = K / 8;
    localparam int unsigned JW     = clog2(N);
    localparam int unsigned PW     = clog2(K + 1);
    localparam int unsigned BW     = (NBytes > 1) ? clog2(NBytes) : 1;

    function automatic int unsigned count_free(input logic [N-1:0] m);
        int unsigned c;
        c = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (((m >> i) & N'(1)) == '0) c = c + 1;
        end
        return c;
    endfunction

    if ((count_free(FROZEN_MASK) != K) || ((K % 8) != 0) || (K < 8) || (K > N))
    begin : g_bad_params
        $error("polar_frame_assembler: N/K/FROZEN_MASK are inconsistent");
    end

    state_t         state_q, state_d;
    logic [BW-1:0]  byte_cnt_q, byte_cnt_d;
    logic [K-1:0]   info_q, info_d;
    logic [JW-1:0]  j_q, j_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [N-1:0]   u_q, u_d;
    logic           u_valid_q, u_valid_d;

    logic [JW-1:0]  wr_addr;
    logic           info_bit;
    logic [BW+2:0]  byte_sh;

`ifdef POLAR_ASM_BITREV_EN
    assign wr_addr = JW'(bitrev(32'(j_q), JW));
`else
    assign wr_addr = j_q;
`endif

    assign info_bit = |(info_q & (K'(1) << ptr_q));
    assign byte_sh  = {byte_cnt_q, 3'b000};

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        info_d     = info_q;
        j_d        = j_q;
        ptr_d      = ptr_q;
        u_d        = u_q;
        u_valid_d  = u_valid_q;
        case (state_q)
            StCollect: begin
                if (in_valid) begin
                    info_d = (info_q & ~(K'(8'hFF) << byte_sh)) | (K'(in_data) << byte_sh);
                    if (byte_cnt_q == BW'(NBytes - 1)) begin
                        byte_cnt_d = '0;
                        state_d    = StScatter;
                        j_d        = '0;
                        ptr_d      = '0;
                        u_d        = '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BW'(1);
                    end
                end
            end
            StScatter: begin
                // Frozen test is always on natural-order j; only the write address may be reversed.
                if (FROZEN_MASK[j_q]) begin
                    u_d[wr_addr] = 1'b0;
                end else begin
                    u_d[wr_addr] = info_bit;
                    ptr_d        = ptr_q + PW'(1);
                end
                if (j_q == JW'(N - 1)) begin
                    state_d   = StHold;
                    u_valid_d = 1'b1;
                end else begin
                    j_d = j_q + JW'(1);
                end
            end
            StHold: begin
                if (u_ready) begin
                    u_valid_d  = 1'b0;
                    state_d    = StCollect;
                    byte_cnt_d = '0;
                end
            end
            default: begin
                state_d   = StCollect;
                u_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StCollect;
            byte_cnt_q <= '0;
            info_q     <= '0;
            j_q        <= '0;
            ptr_q      <= '0;
            u_q        <= '0;
            u_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            info_q     <= info_d;
            j_q        <= j_d;
            ptr_q      <= ptr_d;
            u_q        <= u_d;
            u_valid_q  <= u_valid_d;
        end
    end

    assign in_ready = (state_q == StCollect);
    assign busy     = (state_q == StScatter) || (state_q == StHold);
    assign u_out    = u_q;
    assign u_valid  = u_valid_q;

endmodule

// File: tb/tb_polar_frame_assembler.sv
// Scoreboard bench for polar_frame_assembler: directed cases plus random bytes with
// random backpressure, checked against a position-list reference model.
module tb_polar_frame_assembler;

    localparam int unsigned N = 16;
    localparam int unsigned K = 8;

`ifdef POLAR_ASM_BITREV_EN
    localparam logic [N-1:0] ExpA5 = 16'h8860;
    localparam logic [N-1:0] ExpFF = 16'hE8E8;
    localparam logic [N-1:0] Exp0F = 16'h6060;
`else
    localparam logic [N-1:0] ExpA5 = 16'hA440;
    localparam logic [N-1:0] ExpFF = 16'hFCC0;
    localparam logic [N-1:0] Exp0F = 16'h0CC0;
`endif
    localparam logic [N-1:0] Exp00 = 16'h0000;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] u_out;
    logic         u_valid;
    logic         u_ready;
    logic         busy;

    polar_frame_assembler dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .u_out    (u_out),
        .u_valid  (u_valid),
        .u_ready  (u_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] frame;
        int           acc;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           hs_cyc = 0;
    logic [N-1:0] frozen_mask = 16'h033F;
    logic [K-1:0] part_info = '0;
    int           part_cnt = 0;
    bit           rand_ready = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: walk positions in order, fill each unfrozen one with the next info bit.
    function automatic int addr_of(input int pos);
`ifdef POLAR_ASM_BITREV_EN
        int r = 0;
        for (int b = 0; b < 4; b++) if (((pos >> b) & 1) != 0) r = r | (1 << (3 - b));
        return r;
`else
        return pos;
`endif
    endfunction

    function automatic logic [N-1:0] model_frame(input logic [K-1:0] info);
        logic [N-1:0] u = '0;
        int           p = 0;
        for (int pos = 0; pos < N; pos++) begin
            if (frozen_mask[pos] == 1'b0) begin
                u[addr_of(pos)] = info[p];
                p++;
            end
        end
        return u;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [N-1:0] exp, input bit lit,
                             output int acc);
        bit   done = 0;
        exp_t e;
        acc      = -1;
        in_data  = b;
        in_valid = 1'b1;
        for (int n = 0; n < 500 && !done; n++) begin
            if (in_ready) begin
                tick();
                acc  = cyc;
                done = 1;
            end else begin
                tick();
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            check("send_timeout", 0, 1);
        end else begin
            part_info[8*part_cnt +: 8] = b;
            part_cnt++;
            if (part_cnt == K / 8) begin
                e.frame  = lit ? exp : model_frame(part_info);
                e.acc    = acc;
                sb.push_back(e);
                part_cnt = 0;
            end
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && (sb.size() != 0 || u_valid); n++) tick();
        check("drain", ((sb.size() == 0) && !u_valid) ? 1 : 0, 1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_u_valid"}, u_valid, 0);
        check({tag, "_u_out"}, u_out, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Monitor: samples on the falling edge, away from input changes at posedge+1.
    initial begin
        logic         prev_valid = 0;
        logic         prev_ready = 0;
        logic [N-1:0] prev_u = '0;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_valid = 0;
                continue;
            end
            if (u_valid && !prev_valid) begin
                if (sb.size() == 0) check("unexpected_frame", u_out, 32'hFFFF_FFFF);
                else check("latency", cyc - sb[0].acc, N);
                check("busy_hold", busy, 1);
            end
            if (u_valid && prev_valid && !prev_ready) begin
                check("hold_stable", u_out, prev_u);
                check("hold_in_ready", in_ready, 0);
            end
            if (u_valid && u_ready && sb.size() != 0) begin
                e = sb.pop_front();
                check("frame", u_out, e.frame);
                hs_cyc = cyc + 1;
            end
            prev_valid = u_valid;
            prev_ready = u_ready;
            prev_u     = u_out;
        end
    end

    initial begin
        forever begin
            tick();
            if (rand_ready) u_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int acc;
        reset_n  = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;
        u_ready  = 1'b1;
        #2 reset_n = 1'b0;
        #1 check_reset("por");
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        tick();

        // Basic frame with the encoder always ready.
        send_byte(8'hA5, ExpA5, 1, acc);
        drain();

        // Backpressure: frame must hold, next byte must wait for the handshake.
        u_ready = 1'b0;
        send_byte(8'hFF, ExpFF, 1, acc);
        in_data  = 8'h33;
        in_valid = 1'b1;
        for (int n = 0; n < 100 && !u_valid; n++) tick();
        check("hold_reached", u_valid, 1);
        repeat (5) tick();
        u_ready = 1'b1;
        send_byte(8'h33, '0, 0, acc);
        check("no_early_pop", (acc > hs_cyc) ? 1 : 0, 1);
        drain();

        // Back-to-back bytes with in_valid held high.
        send_byte(8'hFF, ExpFF, 1, acc);
        send_byte(8'h00, Exp00, 1, acc);
        drain();

        // Reset mid-scatter at j=7 discards the partial frame.
        send_byte(8'hAA, '0, 0, acc);
        repeat (7) tick();
        #2 reset_n = 1'b0;
        #1 check_reset("mid_reset");
        sb.delete();
        part_cnt = 0;
        @(negedge clk) reset_n = 1'b1;
        tick();
        send_byte(8'h0F, Exp0F, 1, acc);
        drain();

        // Random bytes, random gaps, random encoder backpressure.
        rand_ready = 1;
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            send_byte(8'($urandom), '0, 0, acc);
        end
        rand_ready = 0;
        tick();
        u_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
